// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path parameters and handshake FSM state encoding.
package uart_rx_fifo_pkg;
    localparam int unsigned WORD_SIZE     = 8;
    localparam int unsigned RX_FIFO_DEPTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } rx_state_e;
endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous show-ahead FIFO: pointer-based storage with count-derived empty/full.
module sync_fifo
#(
    parameter int unsigned WORD_SIZE = uart_rx_fifo_pkg::WORD_SIZE,
    parameter int unsigned DEPTH     = uart_rx_fifo_pkg::RX_FIFO_DEPTH,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_W-1:0]     count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_rd;
    logic                 do_wr;

    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot the write lands in.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: four-phase handshake with the UART receiver feeding a show-ahead FIFO.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned WORD_SIZE = uart_rx_fifo_pkg::WORD_SIZE,
    parameter int unsigned DEPTH     = uart_rx_fifo_pkg::RX_FIFO_DEPTH,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_data_interrupt,
    input  logic [WORD_SIZE-1:0] data,
    output logic                 disable_data_interrupt,
    input  logic                 rd_en,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_W-1:0]     count,
    output logic                 overrun,
    input  logic                 clr_overrun
);
    rx_state_e state;
    logic      capture;
    logic      space;
    logic      wr_en;
    logic      drop;

    assign capture = (state == ST_IDLE) && enable_data_interrupt;
    // When full the FIFO is non-empty, so rd_en is guaranteed to pop.
    assign space   = !full || rd_en;
    assign wr_en   = capture && space;
    assign drop    = capture && !space;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                  <= ST_IDLE;
            disable_data_interrupt <= 1'b0;
            overrun                <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (enable_data_interrupt) begin
                    disable_data_interrupt <= 1'b1;
                    state                  <= ST_ACK;
                end
                ST_ACK: if (!enable_data_interrupt) begin
                    disable_data_interrupt <= 1'b0;
                    state                  <= ST_IDLE;
                end
                default: begin
                    disable_data_interrupt <= 1'b0;
                    state                  <= ST_IDLE;
                end
            endcase
            if (drop)             overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

    sync_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model, decoupled negedge monitor.
module tb_uart_rx_fifo;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable_data_interrupt = 1'b0;
    logic [W-1:0]  data = '0;
    logic          disable_data_interrupt;
    logic          rd_en = 1'b0;
    logic [W-1:0]  rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overrun;
    logic          clr_overrun = 1'b0;

    uart_rx_fifo #(.WORD_SIZE(W), .DEPTH(D)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .enable_data_interrupt  (enable_data_interrupt),
        .data                   (data),
        .disable_data_interrupt (disable_data_interrupt),
        .rd_en                  (rd_en),
        .rd_data                (rd_data),
        .empty                  (empty),
        .full                   (full),
        .count                  (count),
        .overrun                (overrun),
        .clr_overrun            (clr_overrun)
    );

    always #10 clk = ~clk;

    typedef struct {
        int         cnt;
        bit         ovr;
        bit         ack;
        logic [7:0] head;
    } stat_t;

    stat_t      stat_q[$];
    logic [7:0] data_q[$];
    logic [7:0] mq[$];
    bit         m_ack;
    bit         m_ovr;
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ack = 1'b0;
        m_ovr = 1'b0;
    endtask

    // One clock: record expected pre-edge outputs, then advance the model through the edge.
    task automatic cycle(input bit rd, input bit clr);
        stat_t s;
        bit    pop, cap, space;
        rd_en       = rd;
        clr_overrun = clr;
        s.cnt  = mq.size();
        s.ovr  = m_ovr;
        s.ack  = m_ack;
        s.head = (mq.size() > 0) ? mq[0] : 8'h00;
        stat_q.push_back(s);
        pop   = rd && (mq.size() > 0);
        cap   = enable_data_interrupt && !m_ack;
        space = (mq.size() < D) || pop;
        if (pop) data_q.push_back(mq[0]);
        if (cap && !space) m_ovr = 1'b1;
        else if (clr)      m_ovr = 1'b0;
        if (pop) void'(mq.pop_front());
        if (cap && space) mq.push_back(data);
        m_ack = enable_data_interrupt;
        @(posedge clk);
        #2;
    endtask

    function automatic bit pick_rd(input int mode, input int n);
        if (mode == 2) return n == 0;
        if (mode == 1) return $urandom_range(2) == 0;
        return 1'b0;
    endfunction

    // mode 0: no pops, 1: random pops/clears, 2: pop only on the capture edge
    task automatic send_byte(input logic [7:0] b, input int mode);
        int n;
        data = b;
        enable_data_interrupt = 1'b1;
        n = 0;
        do begin
            cycle(pick_rd(mode, n), (mode == 1) && ($urandom_range(7) == 0));
            n++;
        end while (!disable_data_interrupt && n < 8);
        if (!disable_data_interrupt) chk("ack_rise_timeout", 0, 1);
        repeat (2) cycle(pick_rd(mode, 1), 1'b0);
        enable_data_interrupt = 1'b0;
        n = 0;
        do begin
            cycle(pick_rd(mode, 1), 1'b0);
            n++;
        end while (disable_data_interrupt && n < 8);
        if (disable_data_interrupt) chk("ack_fall_timeout", 1, 0);
        cycle(1'b0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() > 0 && n < 64) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        cycle(1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        stat_t s;
        if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            chk("count", int'(count), s.cnt);
            chk("empty", int'(empty), int'(s.cnt == 0));
            chk("full", int'(full), int'(s.cnt == D));
            chk("overrun", int'(overrun), int'(s.ovr));
            chk("ack", int'(disable_data_interrupt), int'(s.ack));
            chk("rd_data", int'(rd_data), int'(s.head));
            if (rd_en && !empty) begin
                if (data_q.size() == 0) chk("pop_unexpected", 1, 0);
                else                    chk("pop_data", int'(rd_data), int'(data_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #5;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_ack", int'(disable_data_interrupt), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) cycle(1'b0, 1'b0);

        send_byte(8'hAA, 0);
        drain();

        for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
        repeat (4) cycle(1'b1, 1'b0);
        for (int i = 16; i < 20; i++) send_byte(8'(i), 0);
        drain();

        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 0);
        send_byte(8'h55, 0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        send_byte(8'h77, 2);
        drain();

        repeat (3) cycle(1'b1, 1'b0);

        data = 8'hC3;
        enable_data_interrupt = 1'b1;
        repeat (2) cycle(1'b0, 1'b0);
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("rst_async_ack", int'(disable_data_interrupt), 0);
        chk("rst_async_count", int'(count), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) cycle(1'b0, 1'b0);
        enable_data_interrupt = 1'b0;
        repeat (2) cycle(1'b0, 1'b0);
        drain();

        for (int i = 0; i < 60; i++) send_byte(8'($urandom), 1);
        drain();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("pop_leftover", data_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
